// File: rtl/softplus_backward.sv
// Softplus backward unit: grad_out = grad_in * sigmoid(x).
// Sigmoid is approximated as 0.5 + 0.5*tanh(x/2), using the Pade form
// tanh(u) ~= u(27+u^2)/(27+9u^2). x > 3 copies grad_in and x < -2 gives +0.
// One float multiplier, one float adder and one float divider are shared
// across the sequence, with one operation per FSM state.
module softplus_backward #(
    parameter logic [31:0] UPPER_BOUND = 32'h40400000,
    parameter logic [31:0] LOWER_BOUND = 32'hC0000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_value,
    input  logic [31:0] grad_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] grad_out
);

    localparam logic [31:0] F_HALF = 32'h3F000000;
    localparam logic [31:0] F_ONE  = 32'h3F800000;
    localparam logic [31:0] F_NINE = 32'h41100000;
    localparam logic [31:0] F_27   = 32'h41D80000;

    typedef enum logic [3:0] {
        S_IDLE, S_U, S_U2, S_A1, S_NUM, S_M9, S_DEN,
        S_DIV, S_HALF, S_SIG, S_CLAMP, S_GRAD, S_DONE
    } state_t;

    state_t      state_q;
    logic        in_ready_q, out_valid_q;
    logic [31:0] grad_out_q;
    logic [31:0] x_q, g_q, u_q, u2_q, a_q, n_q, m_q, d_q, t_q, h_q, s_q;
    logic [31:0] mul_a, mul_b, add_a, add_b;
    logic [31:0] mul_d, add_d, div_d;

    // Round-to-nearest-even and pack. m has its leading one at bit 26,
    // followed by 23 fraction bits, then guard, round and sticky bits.
    // Underflow flushes to a signed zero; overflow gives a signed infinity.
    function automatic logic [31:0] round_pack(input logic s,
                                               input logic signed [10:0] e,
                                               input logic [26:0] m);
        logic                inc;
        logic [23:0]         r;
        logic signed [10:0]  e2;
        logic [31:0]         res;
        inc = m[2] & (m[3] | m[1] | m[0]);
        r   = {1'b0, m[25:3]} + {23'd0, inc};
        e2  = r[23] ? e + 11'sd1 : e;
        if (!m[26] || e2 <= 11'sd0)
            res = {s, 31'h0};
        else if (e2 >= 11'sd255)
            res = {s, 8'hFF, 23'h0};
        else
            res = {s, e2[7:0], r[22:0]};
        return res;
    endfunction

    // Strict a > b on IEEE singles; +0 and -0 compare equal.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if (a[30:0] == 31'h0 && b[30:0] == 31'h0)
            res = 1'b0;
        else if (a[31] != b[31])
            res = ~a[31];
        else if (!a[31])
            res = a[30:0] > b[30:0];
        else
            res = a[30:0] < b[30:0];
        return res;
    endfunction

    // Single-precision multiply; zero exponent is treated as zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [10:0] e;
        logic [26:0]        m;
        logic [31:0]        res;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            res = {s, 31'h0};
        end else begin
            p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
            if (p[47]) begin
                m = {p[47:22], |p[21:0]};
                e = e + 11'sd1;
            end else begin
                m = {p[46:21], |p[20:0]};
            end
            res = round_pack(s, e, m);
        end
        return res;
    endfunction

    // Single-precision add with guard/round/sticky alignment.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        big, sml, res;
        logic [26:0]        ma, mb, sh, m;
        logic [27:0]        sum;
        logic [7:0]         d;
        logic signed [10:0] e;
        int                 lead;
        if (a[30:23] == 8'd0) begin
            res = b;
        end else if (b[30:23] == 8'd0) begin
            res = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
            else begin big = b; sml = a; end
            d  = big[30:23] - sml[30:23];
            ma = {1'b1, big[22:0], 3'b000};
            mb = {1'b1, sml[22:0], 3'b000};
            if (d >= 8'd27) begin
                sh = 27'd1;
            end else begin
                sh    = mb >> d;
                sh[0] = sh[0] | (|(mb & ((27'd1 << d) - 27'd1)));
            end
            e = $signed({3'b000, big[30:23]});
            if (big[31] == sml[31]) begin
                sum = {1'b0, ma} + {1'b0, sh};
                if (sum[27]) begin
                    m = {sum[27:2], sum[1] | sum[0]};
                    e = e + 11'sd1;
                end else begin
                    m = sum[26:0];
                end
                res = round_pack(big[31], e, m);
            end else begin
                sum = {1'b0, ma} - {1'b0, sh};
                if (sum == 28'd0) begin
                    res = 32'h0;
                end else begin
                    lead = 0;
                    for (int i = 0; i < 27; i++)
                        if (sum[i]) lead = i;
                    m   = sum[26:0] << (26 - lead);
                    e   = e - 11'(26 - lead);
                    res = round_pack(big[31], e, m);
                end
            end
        end
        return res;
    endfunction

    // Single-precision divide; the divisor is never zero in this datapath.
    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic               s, lt;
        logic [23:0]        ma, mb, r;
        logic [50:0]        num;
        logic [26:0]        q;
        logic signed [10:0] e;
        logic [31:0]        res;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0) begin
            res = {s, 31'h0};
        end else begin
            ma  = {1'b1, a[22:0]};
            mb  = {1'b1, b[22:0]};
            lt  = ma < mb;
            num = lt ? {ma, 27'd0} : {1'b0, ma, 26'd0};
            q   = 27'(num / {27'd0, mb});
            r   = 24'(num % {27'd0, mb});
            e   = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]})
                  + 11'sd127 - (lt ? 11'sd1 : 11'sd0);
            res = round_pack(s, e, {q[26:1], q[0] | (|r)});
        end
        return res;
    endfunction

    // Operand steering for the shared float units according to the current step.
    always_comb begin
        mul_a = 32'h0;
        mul_b = 32'h0;
        add_a = 32'h0;
        add_b = 32'h0;
        case (state_q)
            S_U:    begin mul_a = x_q;    mul_b = F_HALF; end
            S_U2:   begin mul_a = u_q;    mul_b = u_q;    end
            S_NUM:  begin mul_a = u_q;    mul_b = a_q;    end
            S_M9:   begin mul_a = F_NINE; mul_b = u2_q;   end
            S_HALF: begin mul_a = F_HALF; mul_b = t_q;    end
            S_GRAD: begin mul_a = g_q;    mul_b = s_q;    end
            S_A1:   begin add_a = F_27;   add_b = u2_q;   end
            S_DEN:  begin add_a = F_27;   add_b = m_q;    end
            S_SIG:  begin add_a = F_HALF; add_b = h_q;    end
            default: ;
        endcase
        mul_d = fp_mul(mul_a, mul_b);
        add_d = fp_add(add_a, add_b);
        div_d = fp_div(n_q, d_q);
    end

    // Control FSM and step registers: accept, classify, iterate, hold result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            grad_out_q  <= 32'h0;
            x_q  <= 32'h0; g_q  <= 32'h0; u_q  <= 32'h0; u2_q <= 32'h0;
            a_q  <= 32'h0; n_q  <= 32'h0; m_q  <= 32'h0; d_q  <= 32'h0;
            t_q  <= 32'h0; h_q  <= 32'h0; s_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q        <= x_value;
                        g_q        <= grad_in;
                        in_ready_q <= 1'b0;
                        if (fp_gt(x_value, UPPER_BOUND)) begin
                            grad_out_q  <= grad_in;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (fp_gt(LOWER_BOUND, x_value)) begin
                            grad_out_q  <= 32'h0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_U;
                        end
                    end
                end
                S_U:    begin u_q  <= mul_d; state_q <= S_U2;   end
                S_U2:   begin u2_q <= mul_d; state_q <= S_A1;   end
                S_A1:   begin a_q  <= add_d; state_q <= S_NUM;  end
                S_NUM:  begin n_q  <= mul_d; state_q <= S_M9;   end
                S_M9:   begin m_q  <= mul_d; state_q <= S_DEN;  end
                S_DEN:  begin d_q  <= add_d; state_q <= S_DIV;  end
                S_DIV:  begin t_q  <= div_d; state_q <= S_HALF; end
                S_HALF: begin h_q  <= mul_d; state_q <= S_SIG;  end
                S_SIG:  begin s_q  <= add_d; state_q <= S_CLAMP; end
                S_CLAMP: begin
                    if (fp_gt(s_q, F_ONE))
                        s_q <= F_ONE;
                    else if (fp_gt(32'h0, s_q))
                        s_q <= 32'h0;
                    state_q <= S_GRAD;
                end
                S_GRAD: begin
                    grad_out_q  <= mul_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign grad_out  = grad_out_q;

endmodule

// File: tb/tb_softplus_backward.sv
// Bench for softplus_backward: directed table, handshake/reset sequences and
// random operands against a real-arithmetic model rounded to single each step.
module tb_softplus_backward;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_value;
    logic [31:0] grad_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] grad_out;

    int n_vec = 0;
    int n_err = 0;

    softplus_backward dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_value   (x_value),
        .grad_in   (grad_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_out  (grad_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] x;
        logic [31:0] g;
        logic [31:0] expv;
        int          lat;
        logic        use_model;
    } vec_t;

    // single bits -> real (zero exponent read as signed zero)
    function automatic real f2r(input logic [31:0] a);
        logic [10:0] e11;
        if (a[30:23] == 8'd0) return $bitstoreal({a[31], 63'd0});
        e11 = {3'b000, a[30:23]} + 11'd896;
        return $bitstoreal({a[31], e11, a[22:0], 29'd0});
    endfunction

    // real -> single bits, round to nearest even, flush tiny results to zero
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [52:0] m;
        logic [24:0] rr;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'h0};
        e  = int'(b[62:52]) - 1023 + 127;
        m  = {1'b1, b[51:0]};
        rr = {1'b0, m[52:29]};
        if (m[28:0] > 29'h10000000 || (m[28:0] == 29'h10000000 && m[29]))
            rr = rr + 25'd1;
        if (rr[24]) begin
            rr = rr >> 1;
            e  = e + 1;
        end
        if (e <= 0)   return {b[63], 31'h0};
        if (e >= 255) return {b[63], 8'hFF, 23'h0};
        return {b[63], e[7:0], rr[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // Reference: thresholds, then the Pade sigmoid step by step in single precision.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] g,
                                          output int lat);
        logic [31:0] u, u2, a, n, m, d, t, h, s;
        real xr;
        xr = f2r(x);
        if (xr > 3.0)  begin lat = 1; return g; end
        if (xr < -2.0) begin lat = 1; return 32'h0; end
        lat = 12;
        u  = fmul(x, 32'h3F000000);
        u2 = fmul(u, u);
        a  = fadd(32'h41D80000, u2);
        n  = fmul(u, a);
        m  = fmul(32'h41100000, u2);
        d  = fadd(32'h41D80000, m);
        t  = r2f(f2r(n) / f2r(d));
        h  = fmul(32'h3F000000, t);
        s  = fadd(32'h3F000000, h);
        if (f2r(s) > 1.0)      s = 32'h3F800000;
        else if (f2r(s) < 0.0) s = 32'h0;
        return fmul(g, s);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen.
    task automatic run_op(input logic [31:0] x, input logic [31:0] g,
                          output logic [31:0] got, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        x_value  = x;
        grad_in  = g;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x_value  = $urandom();
        grad_in  = $urandom();
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = grad_out;
    endtask

    task automatic drain();
        int w;
        in_valid = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
    endtask

    vec_t        tbl[8];
    logic [31:0] got, want, hold, xr, gr;
    int          lat, mlat, t0, t1, cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x_value = 32'h0; grad_in = 32'h0;

        tbl[0] = '{32'h40800000, 32'h40200000, 32'h40200000, 1,  1'b0};
        tbl[1] = '{32'hC0400000, 32'hFF800000, 32'h00000000, 1,  1'b0};
        tbl[2] = '{32'h00000000, 32'h3F800000, 32'h3F000000, 12, 1'b0};
        tbl[3] = '{32'h40000000, 32'h3F800000, 32'h0,        12, 1'b1};
        tbl[4] = '{32'h40400000, 32'h3F800000, 32'h0,        12, 1'b1};
        tbl[5] = '{32'hC0000000, 32'h3F800000, 32'h0,        12, 1'b1};
        tbl[6] = '{32'h40400001, 32'hBF800000, 32'hBF800000, 1,  1'b0};
        tbl[7] = '{32'hC0000001, 32'h3F800000, 32'h00000000, 1,  1'b0};
        for (int i = 0; i < 8; i++)
            if (tbl[i].use_model) tbl[i].expv = model(tbl[i].x, tbl[i].g, mlat);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_grad_out", grad_out, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].x, tbl[i].g, got, lat);
            chk($sformatf("tbl%0d_data", i), got, tbl[i].expv);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end
        drain();

        // backpressure: result held, busy, in_valid ignored
        out_ready = 1'b0;
        run_op(32'h40000000, 32'h3F800000, hold, lat);
        chk("bp_lat", 32'(lat), 32'd12);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            x_value  = 32'h40800000;
            grad_in  = 32'h40A00000;
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_grad_out", grad_out, hold);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_retain", grad_out, hold);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("bp_no_spurious", 32'(cnt), 32'd0);

        // back-to-back spacing, computed then saturated
        x_value = 32'h00000000; grad_in = 32'h3F800000; in_valid = 1'b1;
        t0 = -1; t1 = -1;
        for (int c = 0; c < 30; c++) begin
            if (in_ready) begin
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
            @(negedge clk);
        end
        drain();
        chk("ii_computed", 32'(t1 - t0), 32'd13);
        x_value = 32'h40800000; grad_in = 32'h3F800000; in_valid = 1'b1;
        t0 = -1; t1 = -1;
        for (int c = 0; c < 10; c++) begin
            if (in_ready) begin
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
            @(negedge clk);
        end
        drain();
        chk("ii_saturated", 32'(t1 - t0), 32'd2);
        @(negedge clk);

        // reset in the middle of the computed path
        x_value = 32'h40000000; grad_in = 32'h3F800000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_grad_out", grad_out, 32'h0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rst_no_spurious", 32'(cnt), 32'd0);
        want = model(32'hBF800000, 32'h40000000, mlat);
        run_op(32'hBF800000, 32'h40000000, got, lat);
        chk("rst_fresh_data", got, want);
        chk("rst_fresh_lat", 32'(lat), 32'(mlat));
        drain();

        // random operands, |x| in [2^-20, 8)
        for (int i = 0; i < 200; i++) begin
            xr = {1'($urandom()), 8'($urandom_range(129, 107)), 23'($urandom())};
            gr = {1'($urandom()), 8'($urandom_range(150, 100)), 23'($urandom())};
            want = model(xr, gr, mlat);
            run_op(xr, gr, got, lat);
            chk($sformatf("rnd%0d_x%h_data", i, xr), got, want);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
